piton_dcr_noc_decoder: RTL

- Upstream stage of the DCR buffer in the Vortex bridge.
- Accepts Piton NoC non-cacheable store packets addressed to the Vortex DCR window and extracts one DCR write (addr, data) per packet.
- Presents each write on a valid/ready interface to the DCR buffer, then returns a single-flit store-ack packet on the outgoing NoC.
- Malformed or non-store packets are drained and counted.

---
 rtl/piton_dcr_noc_decoder.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/piton_dcr_noc_decoder.sv
// Piton NoC store-packet decoder: pulls one DCR write out of each non-cacheable store,
// hands it to the DCR buffer, then answers with a single-flit store ack.
module piton_dcr_noc_decoder #(
  parameter int          NOC_DATA_WIDTH    = 64,
  parameter int          VX_DCR_ADDR_WIDTH = 8,
  parameter int          VX_DCR_DATA_WIDTH = 32,
  parameter logic [7:0]  MSG_TYPE_STORE    = 8'd15,
  parameter logic [7:0]  MSG_TYPE_ACK      = 8'd27
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         noc_in_val,
  input  logic [NOC_DATA_WIDTH-1:0]    noc_in_data,
  output logic                         noc_in_rdy,
  output logic                         noc_out_val,
  output logic [NOC_DATA_WIDTH-1:0]    noc_out_data,
  input  logic                         noc_out_rdy,
  output logic                         dcr_buffer_wr_valid,
  output logic [VX_DCR_ADDR_WIDTH-1:0] dcr_buffer_wr_addr,
  output logic [VX_DCR_DATA_WIDTH-1:0] dcr_buffer_wr_data,
  input  logic                         vx_buffer_rdy,
  output logic [7:0]                   drop_count
);

  localparam logic [2:0] S_HDR   = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_HDR3  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DCR   = 3'd5;
  localparam logic [2:0] S_ACK   = 3'd6;

  logic [2:0]                   state;
  logic [7:0]                   pkt_len;
  logic [7:0]                   mshr;
  logic [7:0]                   remaining;
  logic                         is_store;
  logic                         word_sel;
  logic [13:0]                  src_chip;
  logic [7:0]                   src_x;
  logic [7:0]                   src_y;
  logic [3:0]                   src_fbits;
  logic [VX_DCR_ADDR_WIDTH-1:0] dcr_addr;
  logic [VX_DCR_DATA_WIDTH-1:0] dcr_data;
  logic                         in_fire;
  logic [7:0]                   hdr_len;
  logic [7:0]                   hdr_type;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Intake is open in every parsing state; closed while a write or ack is outstanding.
  always_comb begin
    noc_in_rdy = 1'b0;
    if (rst_n) begin
      case (state)
        S_HDR, S_ADDR, S_HDR3, S_DATA, S_DRAIN: noc_in_rdy = 1'b1;
        default:                                noc_in_rdy = 1'b0;
      endcase
    end
  end

  assign in_fire             = noc_in_val & noc_in_rdy;
  assign hdr_len             = noc_in_data[29:22];
  assign hdr_type            = noc_in_data[21:14];
  assign dcr_buffer_wr_valid = (state == S_DCR);
  assign dcr_buffer_wr_addr  = dcr_addr;
  assign dcr_buffer_wr_data  = dcr_data;
  assign noc_out_val         = (state == S_ACK);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_HDR;
      pkt_len      <= '0;
      mshr         <= '0;
      remaining    <= '0;
      is_store     <= 1'b0;
      word_sel     <= 1'b0;
      src_chip     <= '0;
      src_x        <= '0;
      src_y        <= '0;
      src_fbits    <= '0;
      dcr_addr     <= '0;
      dcr_data     <= '0;
      noc_out_data <= '0;
      drop_count   <= '0;
    end else begin
      case (state)
        S_HDR: begin
          if (in_fire) begin
            pkt_len <= hdr_len;
            mshr    <= noc_in_data[13:6];
            if (hdr_type == MSG_TYPE_STORE && hdr_len >= 8'd3) begin
              is_store <= 1'b1;
              state    <= S_ADDR;
            end else begin
              is_store   <= 1'b0;
              drop_count <= sat_inc(drop_count);
              if (hdr_len != 8'd0) begin
                remaining <= hdr_len;
                state     <= S_DRAIN;
              end
            end
          end
        end
        S_ADDR: begin
          if (in_fire) begin
            dcr_addr <= noc_in_data[VX_DCR_ADDR_WIDTH+1:2];
            word_sel <= noc_in_data[2];
            state    <= S_HDR3;
          end
        end
        S_HDR3: begin
          if (in_fire) begin
            src_chip  <= noc_in_data[63:50];
            src_x     <= noc_in_data[49:42];
            src_y     <= noc_in_data[41:34];
            src_fbits <= noc_in_data[33:30];
            state     <= S_DATA;
          end
        end
        S_DATA: begin
          if (in_fire) begin
            dcr_data <= word_sel ? noc_in_data[63:32] : noc_in_data[31:0];
            // Trailing data flits of a good store are swallowed without counting a drop.
            if (pkt_len > 8'd3) begin
              remaining <= pkt_len - 8'd3;
              state     <= S_DRAIN;
            end else begin
              state <= S_DCR;
            end
          end
        end
        S_DRAIN: begin
          if (in_fire) begin
            remaining <= remaining - 8'd1;
            if (remaining == 8'd1) state <= is_store ? S_DCR : S_HDR;
          end
        end
        S_DCR: begin
          if (vx_buffer_rdy) begin
            noc_out_data <= {src_chip, src_x, src_y, src_fbits, 8'd0, MSG_TYPE_ACK, mshr, 6'd0};
            state        <= S_ACK;
          end
        end
        S_ACK: begin
          if (noc_out_rdy) state <= S_HDR;
        end
        default: state <= S_HDR;
      endcase
    end
  end

endmodule
